lab2_dg_dispmux: RTL and testbench
==================================

Name: lab2_dg_dispmux

Overview:
- Time-multiplexing driver for the dual 7-segment display. It sits directly upstream of the hex-to-segment decoder: its mux output feeds that decoder.
- Alternates two 4-bit hex digits onto one shared segment bus and drives two active-low anode enables.
- Inserts a blanking interval between digits so segment changes never occur while an anode is on (anti-ghosting).
- Double-buffers digit updates so both digits change atomically at a frame boundary.

Parameters:
- REFRESH_CYCLES, 48000: clk cycles each digit's anode is on (1 ms at 48 MHz); must be >= 1.
- BLANK_CYCLES, 480: clk cycles both anodes are off between digits; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- s0  input  4  requested hex value, digit 0 (right).
- s1  input  4  requested hex value, digit 1 (left).
- load  input  1  capture s0/s1 into the shadow registers this cycle.
- mux  output  4  hex value presented to the segment decoder.
- an0  output  1  digit 0 anode enable, active-low.
- an1  output  1  digit 1 anode enable, active-low.
- pending  output  1  shadow holds an uncommitted update.
- frame  output  1  one-cycle pulse: new frame started, update committed if pending.

Behaviour:
- Reset (reset=0, async):
  - State BLANK1, counter 0.
  - Active digits d0=d1=0, shadow registers 0, pending=0.
  - Outputs: an0=1, an1=1, mux=0, frame=0.
- Counter counts 0..N-1 within each state, with N=REFRESH_CYCLES in SHOW states and BLANK_CYCLES in BLANK states.
- On the cycle the counter equals N-1: advance state and clear the counter. Width is $clog2 of the larger parameter, and it never wraps past N-1.
- State sequence: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0, then repeats. Frame period = 2*(REFRESH_CYCLES+BLANK_CYCLES).
- All outputs are registered, or decoded directly from state/data registers with no combinational path from inputs.
- Anode outputs:
  - an0=0 only in SHOW0; an1=0 only in SHOW1.
  - Both are 1 in BLANK0/BLANK1 and never 0 simultaneously.
- mux output:
  - mux=d0 in BLANK1 and SHOW0; mux=d1 in BLANK0 and SHOW1.
  - mux therefore changes only at a SHOW->BLANK transition, while both anodes are off.
- load:
  - On any cycle with load=1: shadow0<=s0, shadow1<=s1, pending<=1.
  - A later load before commit overwrites the shadow; last write wins.
- Commit: on the SHOW1->BLANK1 transition cycle, if pending=1 then d0<=shadow0, d1<=shadow1, pending<=0.
- frame: asserted for exactly one cycle, the first cycle of BLANK1, whether or not a commit occurred.
- Simultaneous load and commit in the same cycle:
  - Bypass: d0<=s0, d1<=s1, pending<=0.
  - The shadow also takes s0/s1, so the new data is committed, not lost.
- load at any other time does not alter d0/d1 or mux until the next commit.
- Reset asserted mid-frame: immediate return to the reset state; the uncommitted shadow is discarded.
- After reset release: BLANK1 for BLANK_CYCLES cycles, then SHOW0 displaying d0=0.
- The first frame pulse occurs after the first full SHOW0..SHOW1 pass.

Test Plan (REFRESH_CYCLES=4, BLANK_CYCLES=2, frame period 12):
- Reset release, no load:
  - an0=an1=1 for 2 cycles, then an0=0 for 4, both 1 for 2, an1=0 for 4, both 1 for 2, repeating.
  - mux=0 throughout; frame pulses every 12 cycles; an0 and an1 are never both 0.
- load with s0=4'h3, s1=4'hA during SHOW0:
  - pending=1 immediately; mux stays 0 for the rest of the frame.
  - At BLANK1, frame=1, pending=0, mux=3; during SHOW1 of the next frame, mux=A.
- Two loads in one frame (5 then 7 on s0):
  - Only 7 appears after commit; 5 is never displayed.
- load asserted exactly on the SHOW1->BLANK1 transition cycle with s0=4'hE, s1=4'h1:
  - Committed that same cycle; mux=E in the following BLANK1; pending=0.
- Ghosting check across 3 frames of random loads:
  - mux never changes on a cycle where an0=0 or an1=0.
- Reset pulsed low during SHOW1 with pending=1:
  - Outputs return immediately to an0=an1=1, mux=0, pending=0.
  - After release, the sequence restarts from BLANK1 with d0=d1=0.

Source files
------------

// File: rtl/lab2_dg_dispmux.sv
// lab2_dg_dispmux: time-multiplexed driver for a dual 7-segment display.
// Alternates two hex digits on a shared bus, with a blanking gap between
// digits, and commits double-buffered digit updates at frame boundaries.
module lab2_dg_dispmux #(
   parameter int REFRESH_CYCLES = 48000,
   parameter int BLANK_CYCLES   = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   input  logic       load,
   output logic [3:0] mux,
   output logic       an0,
   output logic       an1,
   output logic       pending,
   output logic       frame
);

   localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      SHOW0  = 2'd0,
      BLANK0 = 2'd1,
      SHOW1  = 2'd2,
      BLANK1 = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    d0_q, d0_d, d1_q, d1_d;
   logic [3:0]    sh0_q, sh0_d, sh1_q, sh1_d;
   logic          pending_q, pending_d;
   logic          frame_q, frame_d;
   logic          last;
   logic          commit;

   // Next-state: sequencing counter/state, shadow capture and frame commit.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      d0_d      = d0_q;
      d1_d      = d1_q;
      sh0_d     = sh0_q;
      sh1_d     = sh1_q;
      pending_d = pending_q;

      if (state_q == SHOW0 || state_q == SHOW1) begin
         last = (cnt_q == SHOW_LAST);
      end else begin
         last = (cnt_q == BLANK_LAST);
      end

      if (last) begin
         cnt_d = '0;
         unique case (state_q)
            SHOW0:  state_d = BLANK0;
            BLANK0: state_d = SHOW1;
            SHOW1:  state_d = BLANK1;
            BLANK1: state_d = SHOW0;
         endcase
      end

      // The frame ends as SHOW1 hands over to BLANK1.
      commit  = last && (state_q == SHOW1);
      frame_d = commit;

      if (load) begin
         sh0_d     = s0;
         sh1_d     = s1;
         pending_d = 1'b1;
      end

      if (commit) begin
         pending_d = 1'b0;
         if (load) begin
            // A load on the commit cycle bypasses the shadow so it is not lost.
            d0_d = s0;
            d1_d = s1;
         end else if (pending_q) begin
            d0_d = sh0_q;
            d1_d = sh1_q;
         end
      end
   end

   // State and data registers, cleared asynchronously; reset drops any pending update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= BLANK1;
         cnt_q     <= '0;
         d0_q      <= '0;
         d1_q      <= '0;
         sh0_q     <= '0;
         sh1_q     <= '0;
         pending_q <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together on the edge.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d0_q      <= d0_d;
         d1_q      <= d1_d;
         sh0_q     <= sh0_d;
         sh1_q     <= sh1_d;
         pending_q <= pending_d;
         frame_q   <= frame_d;
      end
   end

   // Outputs decode only from registers; mux swaps digits only entering a BLANK state.
   assign an0     = (state_q != SHOW0);
   assign an1     = (state_q != SHOW1);
   assign mux     = (state_q == SHOW0 || state_q == BLANK1) ? d0_q : d1_q;
   assign pending = pending_q;
   assign frame   = frame_q;

endmodule

// File: tb/tb_lab2_dg_dispmux.sv
// tb_lab2_dg_dispmux: scoreboard bench for lab2_dg_dispmux with
// REFRESH_CYCLES=4, BLANK_CYCLES=2 (frame period 12 cycles).
module tb_lab2_dg_dispmux;

   typedef struct {
      logic       an0;
      logic       an1;
      logic [3:0] mux;
      logic       pending;
      logic       frame;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] s0, s1;
   logic       load;
   logic [3:0] mux;
   logic       an0, an1, pending, frame;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   lab2_dg_dispmux #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .s0      (s0),
      .s1      (s1),
      .load    (load),
      .mux     (mux),
      .an0     (an0),
      .an1     (an1),
      .pending (pending),
      .frame   (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Sample p counts negedges after reset release; phase 0,1 BLANK1, 2-5 SHOW0,
   // 6-7 BLANK0, 8-11 SHOW1. frame pulses on phase 0 of every frame but the first.
   function automatic exp_t make_exp(input int p, input logic [3:0] a, input logic [3:0] b,
                                     input logic pend);
      exp_t e;
      int   ph;
      ph        = p % 12;
      e.an0     = !(ph >= 2 && ph <= 5);
      e.an1     = !(ph >= 8);
      e.mux     = (ph < 6) ? a : b;
      e.pending = pend;
      e.frame   = (ph == 0) && (p > 0);
      return e;
   endfunction

   // Monitor: pops one expectation per sampled cycle, plus an anti-ghosting check.
   initial begin
      exp_t       e;
      logic [3:0] prev_mux;
      logic       ghost_valid;
      ghost_valid = 1'b0;
      prev_mux    = '0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an0", 8'(an0), 8'(e.an0));
            check("an1", 8'(an1), 8'(e.an1));
            check("mux", 8'(mux), 8'(e.mux));
            check("pending", 8'(pending), 8'(e.pending));
            check("frame", 8'(frame), 8'(e.frame));
            if (ghost_valid && (!an0 || !an1)) check("ghost", 8'(mux), 8'(prev_mux));
            prev_mux    = mux;
            ghost_valid = 1'b1;
         end else begin
            ghost_valid = 1'b0;
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) check("drain_timeout", 8'(exp_q.size()), 8'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an0"}, 8'(an0), 8'd1);
      check({tag, "_an1"}, 8'(an1), 8'd1);
      check({tag, "_mux"}, 8'(mux), 8'd0);
      check({tag, "_pending"}, 8'(pending), 8'd0);
      check({tag, "_frame"}, 8'(frame), 8'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed schedule; the displayed digits and pending flag per sample
   // are written out by hand for each scenario.
   initial begin
      logic [3:0] cd0, cd1, nxt0, nxt1;
      logic       pend;
      int         ph;

      reset = 1'b1;
      load  = 1'b0;
      s0    = '0;
      s1    = '0;
      #3 reset = 1'b0;
      #4 check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      cd0 = 4'h0; cd1 = 4'h0; pend = 1'b0; nxt0 = '0; nxt1 = '0;
      for (int p = 0; p < 94; p++) begin
         if (p > 0) begin
            @(posedge clk);
            #1;
         end
         ph = p % 12;
         case (p)
            15: pend = 1'b1;                                  // load 3/A seen
            24: begin cd0 = 4'h3; cd1 = 4'hA; pend = 1'b0; end
            27: pend = 1'b1;                                  // loads 5 then 7
            36: begin cd0 = 4'h7; cd1 = 4'h2; pend = 1'b0; end
            48: begin cd0 = 4'hE; cd1 = 4'h1; pend = 1'b0; end // bypass commit
            87: pend = 1'b1;                                  // load before reset
            default: ;
         endcase
         if (p >= 60 && p <= 84 && ph == 0) begin
            cd0 = nxt0; cd1 = nxt1; pend = 1'b0;
         end
         if (p >= 48 && p < 84 && ph == 4) pend = 1'b1;
         exp_q.push_back(make_exp(p, cd0, cd1, pend));

         load = 1'b0;
         case (p)
            14: begin load = 1'b1; s0 = 4'h3; s1 = 4'hA; end
            26: begin load = 1'b1; s0 = 4'h5; s1 = 4'h5; end
            30: begin load = 1'b1; s0 = 4'h7; s1 = 4'h2; end
            47: begin load = 1'b1; s0 = 4'hE; s1 = 4'h1; end
            86: begin load = 1'b1; s0 = 4'h9; s1 = 4'h9; end
            default: ;
         endcase
         if (p >= 48 && p < 84 && (ph == 3 || ph == 9)) begin
            load = 1'b1;
            s0   = 4'($urandom_range(0, 15));
            s1   = 4'($urandom_range(0, 15));
            if (ph == 9) begin
               nxt0 = s0;
               nxt1 = s1;
            end
         end
      end

      // Sample 93 is in SHOW1 with an update pending; pull reset mid-cycle.
      drain();
      load  = 1'b0;
      reset = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      for (int p = 0; p < 26; p++) begin
         if (p > 0) begin
            @(posedge clk);
            #1;
         end
         exp_q.push_back(make_exp(p, 4'h0, 4'h0, 1'b0));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
